// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port RAM arbiter: channel 0 strict priority, others round-robin
// Optional channel-0 starvation guard: define RAM_ARB_STARVE_GUARD_EN.
module ram_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NCH        = 3,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        req,
   input  logic [NCH-1:0]        we,
   input  logic [NCH*ADDR_W-1:0] addr,
   input  logic [NCH*DATA_W-1:0] wdata,
   output logic [NCH-1:0]        gnt,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic                  ram_we,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic [DATA_W-1:0]     rd_data,
   output logic [NCH-1:0]        rd_valid
);

   localparam int CH_W = $clog2(NCH);

   logic [CH_W-1:0]   rr_ptr;
   logic [RD_LAT-1:0] tag_v;
   logic [CH_W-1:0]   tag_ch [RD_LAT];
   logic              others;
   logic              force_rr;
   logic              rr_hit;
   logic [CH_W-1:0]   rr_win;
   logic              win_valid;
   logic [CH_W-1:0]   win;
   logic [NCH-1:0]    win_oh;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   int                idx;

`ifdef RAM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve_cnt;

   assign force_rr = (starve_cnt == CNT_W'(STARVE_MAX));

   // Counts consecutive channel-0 wins that happened while someone else was waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (win_valid && (win == '0) && others) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
         starve_cnt <= '0;
      end
   end
`else
   logic unused_starve;
   assign unused_starve = ^32'(STARVE_MAX);
   assign force_rr      = 1'b0;
`endif

   // Round-robin search over 1..NCH-1 starting at rr_ptr, wrapping back to 1.
   always_comb begin
      others = |req[NCH-1:1];
      rr_hit = 1'b0;
      rr_win = rr_ptr;
      idx    = 0;
      for (int i = 0; i < NCH - 1; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NCH) idx = idx - (NCH - 1);
         if (!rr_hit && req[CH_W'(idx)]) begin
            rr_hit = 1'b1;
            rr_win = CH_W'(idx);
         end
      end
   end

   always_comb begin
      win_valid = 1'b0;
      win       = '0;
      if (req[0] && !(force_rr && others)) begin
         win_valid = 1'b1;
      end else if (rr_hit) begin
         win_valid = 1'b1;
         win       = rr_win;
      end
      win_oh    = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int c = 0; c < NCH; c++) begin
         if (win_valid && (win == CH_W'(c))) begin
            win_oh[c] = 1'b1;
            sel_we    = we[c];
            sel_addr  = addr[c*ADDR_W +: ADDR_W];
            sel_wdata = wdata[c*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt       <= '0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         rr_ptr    <= CH_W'(1);
      end else begin
         gnt    <= win_oh;
         ram_we <= sel_we;
         if (win_valid) begin
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
         end
         if (win_valid && (win != '0)) begin
            rr_ptr <= (win == CH_W'(NCH - 1)) ? CH_W'(1) : win + CH_W'(1);
         end
      end
   end

   // Read tags travel alongside the RAM latency so data returns to its issuer in order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v    <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_ch[i] <= '0;
         rd_valid <= '0;
         rd_data  <= '0;
      end else begin
         tag_v[0]  <= win_valid & ~sel_we;
         tag_ch[0] <= win;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_ch[i] <= tag_ch[i-1];
         end
         rd_valid <= '0;
         if (tag_v[RD_LAT-1]) begin
            rd_valid[tag_ch[RD_LAT-1]] <= 1'b1;
            rd_data                    <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - bench for ram_port_arbiter, RD_LAT=1 and RD_LAT=2 instances on shared inputs
// Honours RAM_ARB_STARVE_GUARD_EN to match the build under test.
module tb_ram_port_arbiter;
   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int NCH = 3;

   logic            clk   = 1'b0;
   logic            rst   = 1'b1;
   logic [NCH-1:0]  req   = '0;
   logic [NCH-1:0]  we    = '0;
   logic [NCH*AW-1:0] addr  = '0;
   logic [NCH*DW-1:0] wdata = '0;

   logic [NCH-1:0] gnt1, gnt2, rdv1, rdv2;
   logic [AW-1:0]  ra1, ra2;
   logic           rwe1, rwe2;
   logic [DW-1:0]  rwd1, rwd2, rrd1, rrd2, rd1, rd2;
   logic [DW-1:0]  ram_q2 = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom(input logic [7:0] a);
      return (a == 8'h10) ? 8'h3C : (a ^ 8'hFF);
   endfunction

   assign rrd1 = rom(ra1);
   always @(posedge clk) ram_q2 <= rom(ra2);
   assign rrd2 = ram_q2;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .RD_LAT(1), .STARVE_MAX(15)) u1 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt1), .ram_addr(ra1), .ram_we(rwe1), .ram_wdata(rwd1), .ram_rdata(rrd1),
      .rd_data(rd1), .rd_valid(rdv1));

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .RD_LAT(2), .STARVE_MAX(15)) u2 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt2), .ram_addr(ra2), .ram_we(rwe2), .ram_wdata(rwd2), .ram_rdata(rrd2),
      .rd_data(rd2), .rd_valid(rdv2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per edge, pick the winner from the rules and schedule read returns.
   typedef struct { int due; int ch; logic [7:0] a; } rd_ev_t;
   rd_ev_t q1[$];
   rd_ev_t q2[$];
   logic [NCH-1:0] e_gnt, e_rdv1, e_rdv2;
   logic           e_we;
   logic [7:0]     e_addr, e_wdata, e_rd1, e_rd2;
   int  m_rr, m_cnt, m_cyc, m_win, m_c;
   bit  m_others, m_force;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_gnt = '0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
         e_rdv1 = '0; e_rdv2 = '0; e_rd1 = '0; e_rd2 = '0;
         m_rr = 1; m_cnt = 0;
         q1.delete(); q2.delete();
      end else begin
         m_others = (req[NCH-1:1] != '0);
         m_force  = 1'b0;
`ifdef RAM_ARB_STARVE_GUARD_EN
         m_force  = (m_cnt == 15) && m_others;
`endif
         m_win = -1;
         if (req[0] && !m_force) begin
            m_win = 0;
         end else begin
            for (int i = 0; i < NCH - 1; i++) begin
               m_c = 1 + ((m_rr - 1 + i) % (NCH - 1));
               if (m_win < 0 && req[m_c]) m_win = m_c;
            end
         end
         m_cnt = (m_win == 0 && m_others) ? m_cnt + 1 : 0;
         if (m_win > 0) m_rr = (m_win == NCH - 1) ? 1 : m_win + 1;
         e_gnt = '0;
         e_we  = 1'b0;
         if (m_win >= 0) begin
            e_gnt   = NCH'(1) << m_win;
            e_we    = we[m_win];
            e_addr  = addr[m_win*AW +: AW];
            e_wdata = wdata[m_win*DW +: DW];
         end
         e_rdv1 = '0;
         if (q1.size() > 0 && q1[0].due == m_cyc) begin
            e_rdv1 = NCH'(1) << q1[0].ch;
            e_rd1  = rom(q1[0].a);
            void'(q1.pop_front());
         end
         e_rdv2 = '0;
         if (q2.size() > 0 && q2[0].due == m_cyc) begin
            e_rdv2 = NCH'(1) << q2[0].ch;
            e_rd2  = rom(q2[0].a);
            void'(q2.pop_front());
         end
         if (m_win >= 0 && !we[m_win]) begin
            q1.push_back('{m_cyc + 1, m_win, e_addr});
            q2.push_back('{m_cyc + 2, m_win, e_addr});
         end
         m_cyc++;
      end
   end

   always begin
      @(posedge clk);
      #3;
      chk("cyc_gnt1", gnt1, e_gnt);        chk("cyc_gnt2", gnt2, e_gnt);
      chk("cyc_ram_we1", rwe1, e_we);      chk("cyc_ram_we2", rwe2, e_we);
      chk("cyc_ram_addr1", ra1, e_addr);   chk("cyc_ram_addr2", ra2, e_addr);
      chk("cyc_ram_wdata1", rwd1, e_wdata); chk("cyc_ram_wdata2", rwd2, e_wdata);
      chk("cyc_rd_valid1", rdv1, e_rdv1);  chk("cyc_rd_valid2", rdv2, e_rdv2);
      chk("cyc_rd_data1", rd1, e_rd1);     chk("cyc_rd_data2", rd2, e_rd2);
   end

   task automatic set_ch(input int c, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
      req[c] = r;
      we[c]  = w;
      addr[c*AW +: AW]  = a;
      wdata[c*DW +: DW] = d;
   endtask

   initial begin
      logic [NCH-1:0] g [40];
      logic [NCH-1:0] rv [12];
      logic [7:0]     rdat [12];
      m_cyc = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_gnt", gnt1, 0);
      chk("reset_ram_we", rwe1, 0);
      chk("reset_ram_addr", ra1, 0);
      chk("reset_rd_valid", rdv2, 0);
      chk("reset_rd_data", rd2, 0);

      @(negedge clk); set_ch(1, 1, 1, 8'h05, 8'hA5);
      @(posedge clk); #1;
      chk("write_gnt", gnt1, 3'b010);
      chk("write_ram_addr", ra1, 8'h05);
      chk("write_ram_we", rwe1, 1);
      chk("write_ram_wdata", rwd1, 8'hA5);
      @(negedge clk); req = '0;
      @(posedge clk); #1;
      chk("write_we_drop", rwe1, 0);
      chk("write_addr_hold", ra1, 8'h05);
      chk("write_gnt_drop", gnt1, 0);

      @(negedge clk); set_ch(2, 1, 0, 8'h10, 8'h00);
      @(posedge clk); #1;
      chk("read_gnt", gnt1, 3'b100);
      @(negedge clk); req = '0;
      @(posedge clk); #1;
      chk("read_rd_valid_lat1", rdv1, 3'b100);
      chk("read_rd_data_lat1", rd1, 8'h3C);
      chk("read_rd_valid_lat2_early", rdv2, 0);
      @(posedge clk); #1;
      chk("read_rd_valid_lat1_drop", rdv1, 0);
      chk("read_rd_valid_lat2", rdv2, 3'b100);
      chk("read_rd_data_lat2", rd2, 8'h3C);

      @(negedge clk); set_ch(1, 1, 0, 8'h20, 8'h00);
      @(posedge clk); #1;
      chk("inflight_gnt", gnt2, 3'b010);
      @(negedge clk); req = '0; rst = 1'b1;
      #1;
      chk("async_rst_gnt", gnt2, 0);
      chk("async_rst_ram_addr", ra2, 0);
      chk("async_rst_rd_data", rd2, 0);
      #2 rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("post_rst_rd_valid1", rdv1, 0);
         chk("post_rst_rd_valid2", rdv2, 0);
      end

      @(negedge clk);
      for (int c = 0; c < NCH; c++) set_ch(c, 1, 1, 8'(8'h80 + c), 8'(8'h50 + c));
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         g[i] = gnt1;
      end
      @(negedge clk); req = 3'b110;
`ifdef RAM_ARB_STARVE_GUARD_EN
      for (int i = 0; i < 40; i++)
         chk("prio_guard", g[i], (i == 15) ? 3'b010 : (i == 31) ? 3'b100 : 3'b001);
`else
      for (int i = 0; i < 40; i++) chk("prio_strict", g[i], 3'b001);
`endif

      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("rr_alternate", gnt1, (i % 2 == 0) ? 3'b010 : 3'b100);
      end

      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c < 8) begin
            req = 3'b001;
            set_ch(0, 1, 0, 8'(c), 8'h00);
         end else begin
            req = '0;
         end
         @(posedge clk); #1;
         rv[c]   = rdv2;
         rdat[c] = rd2;
      end
      for (int c = 0; c < 12; c++) begin
         if (c >= 2 && c <= 9) begin
            chk("b2b_rd_valid", rv[c], 3'b001);
            chk("b2b_rd_data", rdat[c], 8'(8'hFF - (c - 2)));
         end else begin
            chk("b2b_rd_idle", rv[c], 0);
         end
      end

      repeat (3) @(posedge clk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Parametrised arbiter that multiplexes several requesters onto the single port of the POV column RAM. Typical requesters are the column-scan reader that feeds the LEDs, the ASCII/character writer, and effect generators. Each cycle it picks one requester: channel 0, the display scan, has strict priority, and the remaining channels share access round-robin. It registers the RAM address, write enable and write data, acknowledges the winner, and routes read data back to the issuing channel after a fixed latency.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- NCH, 3, number of requesters; must be ≥2; channel 0 is the display scan
- RD_LAT, 1, RAM read latency in cycles, ≥1
- STARVE_MAX, 15, consecutive channel-0 grants tolerated while others wait (guard build only)

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NCH  request per channel
- we  in  NCH  per-channel write (1) or read (0)
- addr  in  NCH*ADDR_W  per-channel address; channel c is at bits [c*ADDR_W +: ADDR_W]
- wdata  in  NCH*DATA_W  per-channel write data
- gnt  out  NCH  one-hot, one-cycle acknowledge
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data
- rd_data  out  DATA_W  registered read data, shared by all channels
- rd_valid  out  NCH  one-hot, one-cycle pulse that qualifies rd_data for its channel

## Operation
- Requester holds req, we, addr and wdata stable until it sees its gnt bit. It may drop req, or present a new request, in the cycle gnt is high.
- Arbitration is combinational on the current req. The result is registered at the edge.
  - If req[0]=1, channel 0 wins.
  - Otherwise the first requesting channel in 1..NCH-1, searching from rr_ptr with wrap, wins.
- rr_ptr moves to the channel after the last granted non-zero channel; from NCH-1 it wraps to 1. Channel-0 grants leave rr_ptr unchanged.
- On a grant edge the block loads ram_addr, ram_we and ram_wdata from the winner and sets gnt[winner]=1.
- With no request: gnt=0 and ram_we=0. ram_addr and ram_wdata hold their last values.
- Read tracking: a tag pipe RD_LAT deep carries {valid, channel}. On the edge where the tag emerges, rd_data <= ram_rdata and rd_valid[channel] = 1.
- Writes produce no rd_valid.
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, gnt=0, rd_data=0, rd_valid=0, rr_ptr=1, tag pipe cleared, starvation counter=0.
- Reset mid-operation discards in-flight reads: no rd_valid is produced for them after rst deasserts.

## Timing
- Request sampled at edge k: gnt and the ram_* outputs are valid during cycle k.
- Throughput: one grant per cycle. A held req on one channel is granted back to back.
- Read granted at edge k: rd_valid and rd_data are valid in the cycle following edge k+RD_LAT.
- Reads and writes issued back to back complete in issue order. There are no hazards inside the arbiter; RAM read-during-write behaviour belongs to the RAM.

## Configuration
- Macro: RAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each channel-0 grant made while some req[1..NCH-1] is pending. Any other case clears it.
  - When the counter equals STARVE_MAX, the next arbitration ignores req[0] for one cycle and grants the round-robin winner. The counter then clears.
  - Counter width is clog2(STARVE_MAX+1).
- Undefined: strict priority. Channel 0 can starve the other channels indefinitely, and no counter is built.

## Test plan
- Reset: assert rst mid-stream with a read in flight (RD_LAT=2). All outputs go to 0 immediately. No rd_valid appears for two cycles after release.
- Single write: ch1 req, we=1, addr=0x05, wdata=0xA5. gnt=3'b010, ram_addr=0x05, ram_we=1 and ram_wdata=0xA5 appear in the same cycle. Next cycle ram_we=0.
- Read routing: ch2 reads addr 0x10, with the RAM model returning 0x3C. With RD_LAT=1, rd_valid=3'b100 and rd_data=0x3C arrive one cycle after gnt.
- Priority: ch0, ch1 and ch2 all request continuously. Strict build: every gnt is ch0. Guard build with STARVE_MAX=15: 15 ch0 grants, then ch1, 15 ch0 grants, then ch2.
- Round-robin: ch0 idle, ch1 and ch2 both hold req. Grants alternate ch1, ch2, ch1, ch2 with no idle cycles.
- Back-to-back reads on ch0 at addr 0..7 (RAM returns addr^0xFF) with RD_LAT=2. rd_valid[0] is high for 8 consecutive cycles with data 0xFF..0xF8 in order.
